// File: rtl/updown_pkg.sv
// updown_pkg: shared types and defaults for the step/direction generator
// and its counter-side companions.
//   state_t  : generator FSM states
//   DEF_*    : default position width and inter-step gap
//   cnt_w()  : gap counter width, never below one bit
package updown_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_GAP   = 2;

  // S_ prefix keeps the literals clear of the GAP parameter name.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int cnt_w(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/updown_dir_sel.sv
// updown_dir_sel: combinational shortest-path direction picker on a
// modulo-2^WIDTH ring.
//   pos       in  : current position
//   target    in  : destination
//   at_target out : (target - pos) mod 2^WIDTH == 0
//   go_up     out : 1 when the upward distance is no longer than the
//                   downward one (the half-circle tie goes up)
module updown_dir_sel
  import updown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] pos,
  input  logic [WIDTH-1:0] target,
  output logic             at_target,
  output logic             go_up
);

  logic [WIDTH-1:0] dist_up;
  logic [WIDTH-1:0] dist_dn;

  // WIDTH-bit subtraction gives the modular distance for free.
  assign dist_up   = target - pos;
  assign dist_dn   = pos - target;
  assign at_target = (dist_up == '0);
  assign go_up     = (dist_up <= dist_dn);

endmodule

// File: rtl/updown_step_gen.sv
// updown_step_gen: drives a synchronous up/down counter by issuing
// one-cycle step strobes with a direction level until the mirrored
// position reaches a requested target, taking the shorter way round.
//   clk    in  : rising-edge clock
//   reset  in  : synchronous, active-low reset
//   load   in  : preset request, honoured only when not busy
//   d_in   in  : preset value
//   start  in  : move request, honoured only when not busy
//   target in  : destination, captured with an accepted start
//   step   out : one-cycle count strobe for the downstream counter
//   mode   out : direction while step is high (1=up, 0=down)
//   pos    out : mirrored counter position
//   busy   out : move in progress
//   done   out : one-cycle move-complete pulse
module updown_step_gen
  import updown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  output logic             step,
  output logic             mode,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(GAP);
  // Entering GAP preloads GAP-1 so the state lasts exactly GAP cycles.
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t           state;
  logic [WIDTH-1:0] target_q;
  logic [CW-1:0]    gap_cnt;
  logic [WIDTH-1:0] pos_nxt;
  logic             at_target;
  logic             go_up;

  // Direction is decided against the live target input, since the
  // decision is taken in the same cycle the target is captured.
  updown_dir_sel #(
    .WIDTH (WIDTH)
  ) u_dir_sel (
    .pos       (pos),
    .target    (target),
    .at_target (at_target),
    .go_up     (go_up)
  );

  assign pos_nxt = mode ? (pos + WIDTH'(1)) : (pos - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      pos      <= '0;
      target_q <= '0;
      gap_cnt  <= '0;
      step     <= 1'b0;
      mode     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Strobes default low; each branch raises them for one cycle.
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (load) begin
            // Preset wins; a simultaneous start is dropped.
            pos <= d_in;
          end else if (start) begin
            target_q <= target;
            if (at_target) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_STEP;
              step  <= 1'b1;
              busy  <= 1'b1;
              mode  <= go_up;
            end
          end
        end
        S_STEP: begin
          // pos moves on the edge that closes the strobe, matching the
          // edge where the downstream counter samples step.
          pos <= pos_nxt;
          if (pos_nxt == target_q) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (GAP == 0) begin
            state <= S_STEP;
            step  <= 1'b1;
          end else begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_STEP;
            step  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/updown_step_gen.md
# updown_step_gen

Step/direction generator that drives a synchronous up/down counter (clk, reset, load, mode, d_in, q) from the producing side. It accepts a target position, picks the shorter direction modulo 2^WIDTH, and emits single-cycle `step` strobes with a matching `mode` level until its mirrored position `pos` equals the target. It sits upstream of the counter: `step` feeds the counter's count enable, `mode` its direction, and `load`/`d_in` mirror its preset path so `pos` and the counter's `q` stay equal.

## Interface
- WIDTH, 3: position width in bits; positions wrap modulo 2^WIDTH.
- GAP, 2: idle cycles between consecutive steps, ≥0.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- load  input  1  preset request; sampled only when busy=0.
- d_in  input  WIDTH  preset value, taken when load is accepted.
- start  input  1  move request; sampled only when busy=0.
- target  input  WIDTH  destination, captured with an accepted start.
- step  output  1  one-cycle strobe: downstream counter counts this cycle.
- mode  output  1  direction, valid whenever step=1: 1=up, 0=down.
- pos  output  WIDTH  mirrored position after every completed step.
- busy  output  1  high while a move is in progress (STEP/GAP).
- done  output  1  one-cycle pulse: move complete, pos==target.

## Operation
- States: IDLE, STEP, GAP, DONE. busy=1 in STEP and GAP only. done=1 in DONE only.
- Reset (reset=0 at an edge) has priority over everything, including mid-move. Result: state=IDLE, pos=0, step=0, mode=0, busy=0, done=0. Any move in progress is abandoned and no further steps are issued.
- IDLE or DONE, load=1: pos←d_in, state→IDLE. load wins over a simultaneous start; that start is dropped.
- IDLE or DONE, start=1, load=0: target is latched. Direction is chosen by dist_up=(target−pos) mod 2^WIDTH and dist_dn=(pos−target) mod 2^WIDTH:
  - If dist_up=0, go to DONE with no steps.
  - Else mode←(dist_up≤dist_dn) (a tie goes up), and go to STEP.
- STEP: step=1 for exactly one cycle. At the closing edge, pos←pos±1 with wrap (7+1→0, 0−1→7 for WIDTH=3).
  - If the new pos equals the latched target, go to DONE.
  - Else, if GAP=0, stay in STEP; otherwise go to GAP.
- GAP: count GAP cycles, then go to STEP. mode is held constant for the whole move.
- DONE lasts one cycle, then goes to IDLE unless a new start or load is accepted in that cycle.
- start/load while busy=1: ignored, not queued. target changes while busy: ignored.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Let E0 be the edge that accepts start. For a move of k≥1 steps:
  - step is high in the cycles beginning at E0 + i·(GAP+1) edges, for i=0..k−1.
  - done is high in the cycle after the last step.
  - Total latency from E0 to done: (k−1)(GAP+1)+1 cycles.
- k=0: done is high in the cycle after E0. busy stays 0.
- pos changes at the same edge that ends each step cycle, which keeps it equal to the counter's q when the counter samples step.
- Maximum k=2^(WIDTH−1), reached for the half-circle tie.

## Structure
- Package updown_pkg holds the state enum (IDLE, STEP, GAP, DONE) and the default WIDTH and GAP constants.
- Sub-module updown_dir_sel is purely combinational. Inputs: pos, target. Outputs: dist_up==0 flag and the up/down decision. It is reused later by the counter-side comparator.
- Top level contains the FSM, the gap counter (width $clog2(GAP+1), minimum 1), the target register and the pos register.

## Test plan
- Reset then idle: hold reset=0 for 2 edges, release → pos=0, step=0, mode=0, busy=0, done=0, with no spurious strobes for 10 cycles.
- Up move: WIDTH=3, GAP=2, pos=0, start with target=3 → mode=1, step in cycles 0, 3, 6 after E0, pos 1→2→3, done in cycle 7.
- Wrapping down move: pos=0, target=6 → mode=0, 2 steps with pos 7→6, done 4 cycles after E0. Tie case: pos=0, target=4 → mode=1, 4 steps.
- Preset and null move: load=1, d_in=3'b010 together with start=1 → pos=2 and the start is dropped. Next, start with target=2 → done in the next cycle, no step, busy stays 0.
- Busy and reset mid-move: start target=3; issue start target=7 and load while busy → both ignored. Drive reset=0 after the 2nd step → all outputs reach reset values at that edge and no further steps are issued.
